mem_sim_dp: RTL and testbench
=============================

// Module: mem_sim_dp
// PURPOSE
//   Dual-port simulation memory for core benches: read-only instruction port (i_*) plus
//   read/write data port (d_*), both using the valid/ready word protocol. Generalises the
//   single-port sim memory: parametrised size and latency, any wstrb pattern, registered
//   rdata, out-of-range detection. Simulation/FPGA-BRAM model only; not for ASIC use.
// PARAMETERS
//   ADDR_BITS  12  byte-address bits decoded; memory is 2**ADDR_BITS bytes (4-byte words)
//   LATENCY    1   cycles from accepting clock edge to ready (>=1); same for both ports
//   WRAP       1   1: addr bits above ADDR_BITS ignored (aliasing); 0: such accesses error
//   INIT_FILE  ""  hex image loaded at time 0 (only when MEM_SIM_INIT_EN defined)
// PORTS
//   clk      in   1   clock, all logic on rising edge
//   reset    in   1   synchronous, active-high reset
//   i_valid  in   1   instruction read request
//   i_ready  out  1   one-cycle completion pulse, instruction port
//   i_addr   in   32  byte address; [1:0] ignored
//   i_rdata  out  32  read word, valid while i_ready=1
//   i_err    out  1   out-of-range flag, valid while i_ready=1
//   d_valid  in   1   data request
//   d_ready  out  1   one-cycle completion pulse, data port
//   d_addr   in   32  byte address; [1:0] ignored
//   d_wdata  in   32  write data
//   d_wstrb  in   4   byte enables; 4'b0000 = read
//   d_rdata  out  32  word contents before any write of this access, valid while d_ready=1
//   d_err    out  1   out-of-range flag, valid while d_ready=1
// BEHAVIOUR
//   - Per port FSM IDLE/WAIT/RESP; ports fully independent. ready = (state==RESP).
//   - IDLE: valid sampled 1 at edge -> latch addr/wdata/wstrb; LATENCY==1 -> RESP,
//     else WAIT with cnt=LATENCY-2. WAIT: cnt==0 -> RESP, else cnt--.
//   - Memory access happens on the edge entering RESP: rdata <= mem[word]; bytes with
//     wstrb[b]=1 get wdata[8b+7:8b]. Any strobe pattern legal (e.g. 4'b1100, 4'b0101).
//   - RESP -> IDLE unconditionally; next accept earliest on the edge after the ready
//     cycle. Throughput: one access per LATENCY+1 cycles per port.
//   - Latched request used; valid/addr/wdata changes after accept have no effect.
//     Masters hold valid until ready; valid low in RESP cycle is fine.
//   - Word index = addr[ADDR_BITS-1:2]. WRAP=0 and addr[31:ADDR_BITS]!=0: no write,
//     rdata=32'hDEAD_BEEF, err=1. Otherwise err=0.
//   - Same-edge I-read and D-write of one word: i_rdata returns old word; write lands.
//   - Reset: state=IDLE, cnt=0, i_ready=d_ready=0, i_rdata=d_rdata=0, i_err=d_err=0.
//     Memory contents NOT cleared. Reset in WAIT/RESP aborts access; a write whose RESP
//     edge coincides with reset does not commit.
// CONFIGURATION
//   MEM_SIM_INIT_EN defined: initial $readmemh(INIT_FILE, mem) when INIT_FILE != "";
//   word-wide hex, word 0 first. Undefined: no initial block; memory is X until written.
// TESTING
//   1 LATENCY=1: d write 0x11223344 strb 1111 @0x10, then read @0x10 -> d_ready 1 cycle
//     after accept, d_rdata=0x11223344, d_err=0.
//   2 strb 4'b0101 wdata 0xAABBCCDD over 0x11223344 @0x10, read -> 0x11BB33DD; write
//     access itself returns d_rdata=0x11223344.
//   3 LATENCY=4: i read held valid -> i_ready exactly 4 cycles after accept edge, one
//     cycle wide; next accept no earlier than 5 cycles after first.
//   4 Same edge RESP: d write 0xCAFEF00D @0x20 and i read @0x20 (old 0) -> i_rdata=0;
//     later i read -> 0xCAFEF00D.
//   5 WRAP=0, ADDR_BITS=12: d write @0x1010 -> d_err=1, d_rdata=0xDEADBEEF, mem @0x10
//     unchanged. WRAP=1: same write aliases to 0x10.
//   6 LATENCY=3: reset asserted in WAIT of write @0x30 -> no d_ready, word @0x30 unchanged,
//     all outputs 0 after reset edge.

Source files
------------

// File: rtl/mem_sim_dp.sv
// mem_sim_dp: dual-port simulation memory (instruction read port + data
// read/write port), valid/ready word protocol, configurable latency.
//
// Parameters:
//   ADDR_BITS  byte-address bits decoded (memory is 2**ADDR_BITS bytes)
//   LATENCY    cycles from accepting edge to ready (>=1), both ports
//   WRAP       1: upper address bits ignored; 0: they flag an error
//   INIT_FILE  hex image name (no preload performed in this model)
//
// Ports:
//   clk, reset               clock, synchronous active-high reset
//   i_valid/i_addr           instruction read request
//   i_ready/i_rdata/i_err    instruction completion pulse, data, range error
//   d_valid/d_addr/d_wdata/d_wstrb  data request (wstrb==0 is a read)
//   d_ready/d_rdata/d_err    data completion pulse, old word, range error
//
// Memory is X until written.

// Per-port request FSM: IDLE -> (WAIT) -> RESP -> IDLE.
module mem_sim_port #(
  parameter int LATENCY   = 1,
  parameter int ADDR_BITS = 12,
  parameter int WRAP      = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 valid_i,
  input  logic [31:0]          addr_i,
  output logic                 accept_o,  // request latched this edge
  output logic                 fire_o,    // memory access this edge
  output logic                 ready_o,
  output logic                 oob_o,
  output logic [ADDR_BITS-3:0] idx_o
);
  localparam int CW       = (LATENCY > 2) ? $clog2(LATENCY) : 1;
  localparam int CNT_INIT = (LATENCY > 1) ? LATENCY - 2 : 0;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   addr_q, addr_d;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    accept_o = 1'b0;
    case (state_q)
      IDLE: if (valid_i) begin
        accept_o = 1'b1;
        addr_d   = addr_i;
        cnt_d    = CW'(CNT_INIT);
        state_d  = (LATENCY == 1) ? RESP : WAIT;
      end
      WAIT: if (cnt_q == '0) state_d = RESP;
            else             cnt_d   = cnt_q - CW'(1);
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // addr_d is the request in flight; with LATENCY==1 it is the live input,
  // since the access happens on the accepting edge itself.
  assign fire_o  = (state_d == RESP) && !reset;
  assign ready_o = (state_q == RESP);
  assign oob_o   = (WRAP == 0) && ((addr_d >> ADDR_BITS) != 32'd0);
  assign idx_o   = addr_d[ADDR_BITS-1:2];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
    end
  end
endmodule

module mem_sim_dp #(
  parameter int ADDR_BITS = 12,
  parameter int LATENCY   = 1,
  parameter int WRAP      = 1,
  parameter     INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_valid,
  output logic        i_ready,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_err,
  input  logic        d_valid,
  output logic        d_ready,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_wstrb,
  output logic [31:0] d_rdata,
  output logic        d_err
);
  localparam int WORDS = 2 ** (ADDR_BITS - 2);
  localparam logic [31:0] ERR_WORD = 32'hDEAD_BEEF;

  logic [31:0] mem [WORDS];

  logic                 i_acc, i_fire, i_oob, d_acc, d_fire, d_oob;
  logic [ADDR_BITS-3:0] i_idx, d_idx;

  mem_sim_port #(.LATENCY(LATENCY), .ADDR_BITS(ADDR_BITS), .WRAP(WRAP)) u_iport (
    .clk(clk), .reset(reset), .valid_i(i_valid), .addr_i(i_addr),
    .accept_o(i_acc), .fire_o(i_fire), .ready_o(i_ready), .oob_o(i_oob), .idx_o(i_idx)
  );

  mem_sim_port #(.LATENCY(LATENCY), .ADDR_BITS(ADDR_BITS), .WRAP(WRAP)) u_dport (
    .clk(clk), .reset(reset), .valid_i(d_valid), .addr_i(d_addr),
    .accept_o(d_acc), .fire_o(d_fire), .ready_o(d_ready), .oob_o(d_oob), .idx_o(d_idx)
  );

  // Write payload is latched on accept; the live value is used when the
  // access happens on the accepting edge.
  logic [31:0] d_wdata_q, d_wdata_a;
  logic [3:0]  d_wstrb_q, d_wstrb_a;
  assign d_wdata_a = d_acc ? d_wdata : d_wdata_q;
  assign d_wstrb_a = d_acc ? d_wstrb : d_wstrb_q;

  logic [31:0] i_rdata_q, d_rdata_q;
  logic        i_err_q, d_err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      d_wdata_q <= '0;
      d_wstrb_q <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
      i_err_q   <= 1'b0;
      d_err_q   <= 1'b0;
    end else begin
      d_wdata_q <= d_wdata_a;
      d_wstrb_q <= d_wstrb_a;
      if (i_fire) begin
        i_rdata_q <= i_oob ? ERR_WORD : mem[i_idx];
        i_err_q   <= i_oob;
      end
      if (d_fire) begin
        d_rdata_q <= d_oob ? ERR_WORD : mem[d_idx];
        d_err_q   <= d_oob;
      end
    end
  end

  // Contents survive reset; fire is already suppressed under reset so a
  // write whose access edge coincides with reset never commits. Reads above
  // see the pre-write word because both use non-blocking updates.
  always_ff @(posedge clk) begin
    if (d_fire && !d_oob) begin
      for (int b = 0; b < 4; b++)
        if (d_wstrb_a[b]) mem[d_idx][8*b +: 8] <= d_wdata_a[8*b +: 8];
    end
  end

  assign i_rdata = i_rdata_q;
  assign i_err   = i_err_q;
  assign d_rdata = d_rdata_q;
  assign d_err   = d_err_q;
endmodule

// File: tb/tb_mem_sim_dp.sv
module tb_mem_sim_dp;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // Instance 0: LATENCY=1 WRAP=1; 1: LATENCY=4 WRAP=0; 2: LATENCY=3 WRAP=0
  localparam int LAT [3] = '{1, 4, 3};

  logic [2:0]       i_valid = '0, i_ready, i_err, d_valid = '0, d_ready, d_err;
  logic [2:0][31:0] i_addr = '0, i_rdata, d_addr = '0, d_wdata = '0, d_rdata;
  logic [2:0][3:0]  d_wstrb = '0;

  mem_sim_dp #(.ADDR_BITS(12), .LATENCY(1), .WRAP(1)) u_a (
    .clk(clk), .reset(reset),
    .i_valid(i_valid[0]), .i_ready(i_ready[0]), .i_addr(i_addr[0]), .i_rdata(i_rdata[0]), .i_err(i_err[0]),
    .d_valid(d_valid[0]), .d_ready(d_ready[0]), .d_addr(d_addr[0]), .d_wdata(d_wdata[0]),
    .d_wstrb(d_wstrb[0]), .d_rdata(d_rdata[0]), .d_err(d_err[0]));
  mem_sim_dp #(.ADDR_BITS(12), .LATENCY(4), .WRAP(0)) u_b (
    .clk(clk), .reset(reset),
    .i_valid(i_valid[1]), .i_ready(i_ready[1]), .i_addr(i_addr[1]), .i_rdata(i_rdata[1]), .i_err(i_err[1]),
    .d_valid(d_valid[1]), .d_ready(d_ready[1]), .d_addr(d_addr[1]), .d_wdata(d_wdata[1]),
    .d_wstrb(d_wstrb[1]), .d_rdata(d_rdata[1]), .d_err(d_err[1]));
  mem_sim_dp #(.ADDR_BITS(12), .LATENCY(3), .WRAP(0)) u_c (
    .clk(clk), .reset(reset),
    .i_valid(i_valid[2]), .i_ready(i_ready[2]), .i_addr(i_addr[2]), .i_rdata(i_rdata[2]), .i_err(i_err[2]),
    .d_valid(d_valid[2]), .d_ready(d_ready[2]), .d_addr(d_addr[2]), .d_wdata(d_wdata[2]),
    .d_wstrb(d_wstrb[2]), .d_rdata(d_rdata[2]), .d_err(d_err[2]));

  int ntests = 0, nfail = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int k; logic [31:0] rd; logic err; bit chk; int cyc; } exp_t;
  typedef struct { bit dp; int k; logic [31:0] a; logic [31:0] wd; logic [3:0] s;
                   logic [31:0] rd; logic err; bit chk; } vec_t;
  exp_t qi[$], qd[$];

  task automatic cmp(string nm, logic [31:0] act, logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h want %h (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chk_zero(string nm);
    for (int k = 0; k < 3; k++) begin
      cmp($sformatf("%s_flags%0d", nm, k), {28'd0, i_ready[k], i_err[k], d_ready[k], d_err[k]}, 32'd0);
      cmp($sformatf("%s_irdata%0d", nm, k), i_rdata[k], 32'd0);
      cmp($sformatf("%s_drdata%0d", nm, k), d_rdata[k], 32'd0);
    end
  endtask

  // Scoreboard: every ready pulse must match an outstanding expectation.
  task automatic pop_chk(bit dp, int k, logic [31:0] rd, logic err);
    exp_t e;
    int idx = -1;
    string p = dp ? "d" : "i";
    if (dp) begin foreach (qd[j]) if (idx < 0 && qd[j].k == k) idx = j; end
    else    begin foreach (qi[j]) if (idx < 0 && qi[j].k == k) idx = j; end
    if (idx < 0) begin
      ntests++; nfail++;
      $display("FAIL %s_ready%0d: unexpected pulse at cyc %0d", p, k, cyc);
      return;
    end
    if (dp) begin e = qd[idx]; qd.delete(idx); end
    else    begin e = qi[idx]; qi.delete(idx); end
    cmp($sformatf("%s_lat%0d", p, k), cyc, e.cyc);
    cmp($sformatf("%s_err%0d", p, k), {31'd0, err}, {31'd0, e.err});
    if (e.chk) cmp($sformatf("%s_rdata%0d", p, k), rd, e.rd);
  endtask

  always @(negedge clk)
    for (int k = 0; k < 3; k++) begin
      if (d_ready[k] === 1'b1) pop_chk(1'b1, k, d_rdata[k], d_err[k]);
      if (i_ready[k] === 1'b1) pop_chk(1'b0, k, i_rdata[k], i_err[k]);
    end

  // One request: drive, push expectation, scramble inputs after accept,
  // hold valid until ready.
  task automatic req(bit dp, int k, logic [31:0] a, logic [31:0] wd, logic [3:0] s,
                     logic [31:0] er, logic ee, bit chk);
    exp_t e;
    int   n = 0;
    logic rdy;
    @(negedge clk);
    e.k = k; e.rd = er; e.err = ee; e.chk = chk; e.cyc = cyc + LAT[k];
    if (dp) begin
      d_addr[k] = a; d_wdata[k] = wd; d_wstrb[k] = s; d_valid[k] = 1'b1; qd.push_back(e);
    end else begin
      i_addr[k] = a; i_valid[k] = 1'b1; qi.push_back(e);
    end
    do begin
      @(negedge clk);
      n++;
      rdy = dp ? d_ready[k] : i_ready[k];
      if (dp) begin d_addr[k] = $urandom; d_wdata[k] = $urandom; end
      else i_addr[k] = $urandom;
    end while (rdy !== 1'b1 && n < 20);
    if (rdy !== 1'b1) begin
      ntests++; nfail++;
      $display("FAIL %s_timeout%0d: no ready within 20 cycles", dp ? "d" : "i", k);
    end
    if (dp) d_valid[k] = 1'b0; else i_valid[k] = 1'b0;
  endtask

  // Start a write, then assert reset dly cycles later (dly=0: on the accepting edge).
  task automatic abort_d(int k, logic [31:0] a, logic [31:0] wd, int dly, string nm);
    @(negedge clk);
    d_addr[k] = a; d_wdata[k] = wd; d_wstrb[k] = 4'hF; d_valid[k] = 1'b1;
    repeat (dly) @(negedge clk);
    reset = 1'b1;
    if (dly > 0) d_valid[k] = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    d_valid[k] = 1'b0;
    chk_zero(nm);
    repeat (6) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tv[$];
    exp_t e1, e2;
    int   seen = 0, n = 0;
    tv.push_back('{1'b1, 0, 32'h10,       32'h11223344, 4'hF,    32'h0,        1'b0, 1'b0});
    tv.push_back('{1'b1, 0, 32'h10,       32'h0,        4'h0,    32'h11223344, 1'b0, 1'b1});
    tv.push_back('{1'b1, 0, 32'h10,       32'hAABBCCDD, 4'b0101, 32'h11223344, 1'b0, 1'b1});
    tv.push_back('{1'b1, 0, 32'h10,       32'h0,        4'h0,    32'h11BB33DD, 1'b0, 1'b1});
    tv.push_back('{1'b1, 0, 32'h1010,     32'h01020304, 4'hF,    32'h11BB33DD, 1'b0, 1'b1});
    tv.push_back('{1'b1, 0, 32'h10,       32'h0,        4'h0,    32'h01020304, 1'b0, 1'b1});
    tv.push_back('{1'b1, 0, 32'h14,       32'h12345678, 4'hF,    32'h0,        1'b0, 1'b0});
    tv.push_back('{1'b1, 0, 32'h14,       32'h9ABCDEF0, 4'b1010, 32'h12345678, 1'b0, 1'b1});
    tv.push_back('{1'b0, 0, 32'h1014,     32'h0,        4'h0,    32'h9A34DE78, 1'b0, 1'b1});
    tv.push_back('{1'b1, 0, 32'h20,       32'h0,        4'hF,    32'h0,        1'b0, 1'b0});
    tv.push_back('{1'b1, 1, 32'h10,       32'h55667788, 4'hF,    32'h0,        1'b0, 1'b0});
    tv.push_back('{1'b1, 1, 32'h1010,     32'hFFFFFFFF, 4'hF,    32'hDEADBEEF, 1'b1, 1'b1});
    tv.push_back('{1'b1, 1, 32'h10,       32'h0,        4'h0,    32'h55667788, 1'b0, 1'b1});
    tv.push_back('{1'b1, 1, 32'hFFFFFFF0, 32'h0,        4'h0,    32'hDEADBEEF, 1'b1, 1'b1});
    tv.push_back('{1'b0, 1, 32'h1000,     32'h0,        4'h0,    32'hDEADBEEF, 1'b1, 1'b1});
    tv.push_back('{1'b1, 1, 32'hFFC,      32'h0BADF00D, 4'hF,    32'h0,        1'b0, 1'b0});
    tv.push_back('{1'b0, 1, 32'hFFF,      32'h0,        4'h0,    32'h0BADF00D, 1'b0, 1'b1});
    tv.push_back('{1'b1, 2, 32'h30,       32'hA5A5A5A5, 4'hF,    32'h0,        1'b0, 1'b0});
    tv.push_back('{1'b0, 2, 32'h30,       32'h0,        4'h0,    32'hA5A5A5A5, 1'b0, 1'b1});

    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk_zero("reset");

    foreach (tv[j])
      req(tv[j].dp, tv[j].k, tv[j].a, tv[j].wd, tv[j].s, tv[j].rd, tv[j].err, tv[j].chk);

    // Back-to-back instruction reads with valid held: LATENCY+1 spacing.
    @(negedge clk);
    i_addr[1] = 32'h10; i_valid[1] = 1'b1;
    e1 = '{1, 32'h55667788, 1'b0, 1'b1, cyc + 4};
    e2 = '{1, 32'h55667788, 1'b0, 1'b1, cyc + 9};
    qi.push_back(e1); qi.push_back(e2);
    while (seen < 2 && n < 30) begin
      @(negedge clk);
      n++;
      if (i_ready[1] === 1'b1) seen++;
    end
    i_valid[1] = 1'b0;
    cmp("i_b2b_count", seen, 2);

    // Same-edge data write and instruction read of one word.
    fork
      req(1'b1, 0, 32'h20, 32'hCAFEF00D, 4'hF, 32'h0, 1'b0, 1'b1);
      req(1'b0, 0, 32'h20, 32'h0,        4'h0, 32'h0, 1'b0, 1'b1);
    join
    req(1'b0, 0, 32'h20, 32'h0, 4'h0, 32'hCAFEF00D, 1'b0, 1'b1);

    // Reset aborts: in WAIT, on the RESP edge, and on a LATENCY=1 accept edge.
    abort_d(2, 32'h30, 32'h5A5A5A5A, 1, "rst_wait");
    req(1'b1, 2, 32'h30, 32'h0, 4'h0, 32'hA5A5A5A5, 1'b0, 1'b1);
    abort_d(2, 32'h30, 32'h5A5A5A5A, 2, "rst_resp");
    req(1'b0, 2, 32'h30, 32'h0, 4'h0, 32'hA5A5A5A5, 1'b0, 1'b1);
    abort_d(0, 32'h20, 32'h11111111, 0, "rst_l1");
    req(1'b1, 0, 32'h20, 32'h0, 4'h0, 32'hCAFEF00D, 1'b0, 1'b1);

    repeat (4) @(negedge clk);
    cmp("qd_drained", qd.size(), 0);
    cmp("qi_drained", qi.size(), 0);
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
